// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the RAM arbiter and its callers: FSM states, port ids, bus widths.
// Pure declarations; no logic, no latency.
// No flow control of its own.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Two-way round-robin pick: chooses the requester that did not win last time on a tie.
// Purely combinational, zero latency.
// No backpressure; the caller decides when to act on win_vld.
module rr_pick
  import ram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic win,
  output logic win_vld
);

  assign win_vld = req0 | req1;
  assign win     = (req0 && req1) ? ((rr_last == PORT0) ? PORT1 : PORT0)
                                  : (req1 ? PORT1 : PORT0);

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between two req/ack masters with round-robin and capped locked bursts.
// Latency: write 3 cycles req-to-ack, read 3 + RAM_LAT; one idle cycle between grants.
// Masters hold req until ack; the non-owner simply waits with req high.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int RAM_LAT   = 1,
  parameter int BURST_MAX = 4,
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [2:0] LAT_INIT  = 3'(RAM_LAT);
  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  arb_state_t    state, state_nxt;
  logic          owner, rr_last;
  logic [3:0]    burst_cnt;
  logic [2:0]    lat_cnt;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata0_q, rdata1_q;
  logic          pick, pick_vld;
  logic          grant, burst_go, rd_done;
  logic          own_req, own_lock;
  logic          src, src_we;
  logic [AW-1:0] src_addr;
  logic [DW-1:0] src_wdata;

  rr_pick u_pick (
    .req0    (m0_req),
    .req1    (m1_req),
    .rr_last (rr_last),
    .win     (pick),
    .win_vld (pick_vld)
  );

  assign own_req  = (owner == PORT1) ? m1_req  : m0_req;
  assign own_lock = (owner == PORT1) ? m1_lock : m0_lock;

  // A fresh grant loads from the picked port, a burst continuation from the current owner.
  assign src       = grant ? pick : owner;
  assign src_we    = (src == PORT1) ? m1_we    : m0_we;
  assign src_addr  = (src == PORT1) ? m1_addr  : m0_addr;
  assign src_wdata = (src == PORT1) ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    burst_go  = 1'b0;
    rd_done   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = we_q ? ACK : WAIT;
      WAIT: begin
        if (lat_cnt <= 3'd1) begin
          rd_done   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (own_lock && own_req && (burst_cnt < BURST_LIM)) begin
          burst_go  = 1'b1;
          state_nxt = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= PORT0;
      rr_last   <= PORT1;
      burst_cnt <= 4'd0;
      lat_cnt   <= 3'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      if (grant || burst_go) begin
        owner   <= src;
        we_q    <= src_we;
        addr_q  <= src_addr;
        wdata_q <= src_wdata;
      end
      if (grant)         burst_cnt <= 4'd1;
      else if (burst_go) burst_cnt <= burst_cnt + 4'd1;
      if (state == ISSUE && !we_q) lat_cnt <= LAT_INIT;
      else if (state == WAIT)      lat_cnt <= lat_cnt - 3'd1;
      if (rd_done) begin
        if (owner == PORT1) rdata1_q <= ram_rdata;
        else                rdata0_q <= ram_rdata;
      end
      if (state == ACK && !burst_go) rr_last <= owner;
    end
  end

  assign m0_gnt    = (state != IDLE) && (owner == PORT0);
  assign m1_gnt    = (state != IDLE) && (owner == PORT1);
  assign m0_ack    = (state == ACK) && (owner == PORT0);
  assign m1_ack    = (state == ACK) && (owner == PORT1);
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign ram_en    = (state == ISSUE);
  assign ram_we    = (state == ISSUE) && we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule
